// File: rtl/matrix_result_display_if.sv
// Result-frame handshake between the 2x2 matrix multiplier and the display stage.
// The master presents a frame; the slave accepts it when res_ready is high.
interface matrix_result_display_if;
    logic        res_valid;
    logic [15:0] res_in;
    logic        err_in;
    logic        res_ready;

    modport master (
        output res_valid,
        output res_in,
        output err_in,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_in,
        input  err_in,
        output res_ready
    );
endinterface

// File: rtl/matrix_result_display.sv
// Captures a 2x2 result frame and time-multiplexes the four nibbles onto one
// seven-segment digit, or shows an "E" on every digit for an error frame.
module matrix_result_display #(
    parameter int unsigned DWELL_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    matrix_result_display_if.slave  up,
    output logic [6:0]              seg,
    output logic [3:0]              digit_sel,
    output logic                    frame_done,
    output logic                    error
);

    localparam int unsigned     CntW    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StShow, StErr} state_e;

    state_e          state_q, state_d;
    logic [15:0]     data_q, data_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            boundary;
    logic            capture;
    logic [3:0]      nibble;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        unique case (v)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    // Last cycle of the r22 dwell: the only point a new frame may cut in.
    assign boundary     = (state_q == StShow) && (idx_q == 2'd3) && (cnt_q == CntLast);
    assign up.res_ready = (state_q != StShow) || boundary;
    assign capture      = up.res_valid && up.res_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (capture) begin
            idx_d = 2'd0;
            cnt_d = '0;
            if (up.err_in) begin
                state_d = StErr;
            end else begin
                state_d = StShow;
                data_d  = up.res_in;
            end
        end else if (state_q == StShow) begin
            if (cnt_q == CntLast) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign nibble = data_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg        = 7'h00;
        digit_sel  = 4'b0000;
        frame_done = 1'b0;
        error      = 1'b0;
        unique case (state_q)
            StShow: begin
                seg        = glyph(nibble);
                digit_sel  = 4'b0001 << idx_q;
                frame_done = boundary;
            end
            StErr: begin
                seg       = 7'h79;
                digit_sel = 4'b1111;
                error     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matrix_result_display.sv
// Bench for matrix_result_display: directed sequences and a glyph table on two
// instances (dwell 4 and dwell 1), with a cycle-count reference model checked every cycle.
module tb_matrix_result_display;

    localparam int DA = 4;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    matrix_result_display_if ifa ();
    matrix_result_display_if ifb ();

    logic [6:0] seg_a, seg_b;
    logic [3:0] sel_a, sel_b;
    logic       fd_a, fd_b, err_a, err_b;

    matrix_result_display #(.DWELL_CYCLES(DA)) dut_a (
        .clk(clk), .reset(reset), .up(ifa),
        .seg(seg_a), .digit_sel(sel_a), .frame_done(fd_a), .error(err_a)
    );

    matrix_result_display #(.DWELL_CYCLES(DB)) dut_b (
        .clk(clk), .reset(reset), .up(ifb),
        .seg(seg_b), .digit_sel(sel_b), .frame_done(fd_b), .error(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the display position is a plain cycle count since capture.
    typedef enum {MIdle, MShow, MErr} mmode_t;
    mmode_t      m_mode[2];
    logic [15:0] m_data[2];
    int          m_n[2];
    int          m_d[2];
    logic [6:0]  glyph_tab[16];
    logic        acc_a, acc_b;

    function automatic logic m_last(int u);
        return (m_mode[u] == MShow) && (((m_n[u] - 1) % (4 * m_d[u])) == 4 * m_d[u] - 1);
    endfunction

    function automatic logic m_ready(int u);
        return (m_mode[u] != MShow) || m_last(u);
    endfunction

    function automatic int m_digit(int u);
        return ((m_n[u] - 1) / m_d[u]) % 4;
    endfunction

    function automatic logic [6:0] m_seg(int u);
        logic [15:0] d;
        if (m_mode[u] == MIdle) return 7'h00;
        if (m_mode[u] == MErr) return 7'h79;
        d = m_data[u];
        return glyph_tab[d[4*m_digit(u) +: 4]];
    endfunction

    function automatic logic [3:0] m_sel(int u);
        if (m_mode[u] == MIdle) return 4'b0000;
        if (m_mode[u] == MErr) return 4'b1111;
        return 4'(1 << m_digit(u));
    endfunction

    task automatic model_edge(input int u, input logic v, input logic [15:0] d, input logic e);
        if (v && m_ready(u)) begin
            if (e) m_mode[u] = MErr;
            else begin
                m_mode[u] = MShow;
                m_data[u] = d;
                m_n[u]    = 1;
            end
        end else if (m_mode[u] == MShow) begin
            m_n[u]++;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_mode[u] = MIdle;
            m_data[u] = '0;
            m_n[u]    = 0;
        end
    endtask

    task automatic check_model(input int u);
        string p;
        p = (u == 0) ? "a" : "b";
        check({p, "_seg"},   (u == 0) ? seg_a : seg_b, m_seg(u));
        check({p, "_sel"},   (u == 0) ? sel_a : sel_b, m_sel(u));
        check({p, "_ready"}, (u == 0) ? ifa.res_ready : ifb.res_ready, m_ready(u));
        check({p, "_done"},  (u == 0) ? fd_a : fd_b, m_last(u));
        check({p, "_error"}, (u == 0) ? err_a : err_b, m_mode[u] == MErr);
    endtask

    task automatic tick();
        acc_a = !reset && ifa.res_valid && m_ready(0);
        acc_b = !reset && ifb.res_valid && m_ready(1);
        @(posedge clk);
        if (!reset) begin
            model_edge(0, ifa.res_valid, ifa.res_in, ifa.err_in);
            model_edge(1, ifb.res_valid, ifb.res_in, ifb.err_in);
        end
        #1;
        check_model(0);
        check_model(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asserts reset between edges and checks the idle outputs before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_seg",   seg_a, 7'h00);
        check("rst_sel",   sel_a, 4'b0000);
        check("rst_ready", ifa.res_ready, 1'b1);
        check("rst_done",  fd_a, 1'b0);
        check("rst_error", err_a, 1'b0);
        check_model(1);
        tick();
        reset = 1'b0;
    endtask

    task automatic send_a(input logic [15:0] d, input logic e);
        ifa.res_valid = 1'b1;
        ifa.res_in    = d;
        ifa.err_in    = e;
        tick();
        ifa.res_valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [27:0] segs;   // {r22, r21, r12, r11} glyphs
    } vec_t;

    vec_t vecs[6];

    logic [6:0] seg_tab[4];
    logic [3:0] sel_tab[4];

    initial begin
        glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_d[0] = DA;
        m_d[1] = DB;
        vecs[0] = '{16'h8421, 1'b0, {7'h7F, 7'h66, 7'h5B, 7'h06}};
        vecs[1] = '{16'hFEDC, 1'b0, {7'h71, 7'h79, 7'h5E, 7'h39}};
        vecs[2] = '{16'h7650, 1'b0, {7'h07, 7'h7D, 7'h6D, 7'h3F}};
        vecs[3] = '{16'hBA93, 1'b0, {7'h7C, 7'h77, 7'h6F, 7'h4F}};
        vecs[4] = '{16'h1234, 1'b1, {7'h79, 7'h79, 7'h79, 7'h79}};
        vecs[5] = '{16'h0008, 1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h7F}};
        seg_tab = '{7'h06, 7'h5B, 7'h66, 7'h7F};
        sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        reset = 1'b1;
        ifa.res_valid = 1'b0; ifa.res_in = '0; ifa.err_in = 1'b0;
        ifb.res_valid = 1'b0; ifb.res_in = '0; ifb.err_in = 1'b0;
        model_reset();
        do_reset();

        // Normal frame, dwell 4, through the wrap.
        send_a(16'h8421, 1'b0);
        for (int n = 1; n <= 17; n++) begin
            check("nf_sel",   sel_a, sel_tab[(n == 17) ? 0 : (n - 1) / 4]);
            check("nf_seg",   seg_a, seg_tab[(n == 17) ? 0 : (n - 1) / 4]);
            check("nf_done",  fd_a, n == 16);
            check("nf_ready", ifa.res_ready, n == 16);
            if (n < 17) tick();
        end

        // Handshake: valid held from cycle 6, accepted only at cycle 16.
        ticks(5);
        ifa.res_valid = 1'b1; ifa.res_in = 16'h0000; ifa.err_in = 1'b0;
        for (int c = 6; c <= 16; c++) begin
            check("hs_ready", ifa.res_ready, c == 16);
            check("hs_sel",   sel_a, sel_tab[(c - 1) / 4]);
            check("hs_seg",   seg_a, seg_tab[(c - 1) / 4]);
            tick();
        end
        ifa.res_valid = 1'b0;
        check("hs_new_seg", seg_a, 7'h3F);
        check("hs_new_sel", sel_a, 4'b0001);

        // Error frame on the boundary, then recovery.
        ticks(15);
        check("err_bnd_ready", ifa.res_ready, 1'b1);
        send_a(16'hABCD, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("err_flag",  err_a, 1'b1);
            check("err_seg",   seg_a, 7'h79);
            check("err_sel",   sel_a, 4'b1111);
            check("err_ready", ifa.res_ready, 1'b1);
            tick();
        end
        send_a(16'h0002, 1'b0);
        check("rec_seg",   seg_a, 7'h5B);
        check("rec_sel",   sel_a, 4'b0001);
        check("rec_error", err_a, 1'b0);

        // Reset during cycle 7 of a frame, then restart.
        ticks(15);
        send_a(16'h8421, 1'b0);
        ticks(6);
        check("mid_sel_pre", sel_a, 4'b0010);
        do_reset();
        send_a(16'h8421, 1'b0);
        check("post_rst_seg", seg_a, 7'h06);
        check("post_rst_sel", sel_a, 4'b0001);
        ticks(4);
        check("post_rst_seg5", seg_a, 7'h5B);

        // Glyph table on the dwell-1 instance.
        foreach (vecs[v]) begin
            for (int w = 0; w < 8 && !m_ready(1); w++) tick();
            check("tbl_ready", ifb.res_ready, 1'b1);
            ifb.res_valid = 1'b1; ifb.res_in = vecs[v].data; ifb.err_in = vecs[v].err;
            tick();
            ifb.res_valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check("tbl_seg",  seg_b, vecs[v].segs[7*k +: 7]);
                check("tbl_sel",  sel_b, vecs[v].err ? 4'b1111 : 4'(1 << k));
                check("tbl_done", fd_b, !vecs[v].err && k == 3);
                tick();
            end
        end

        // Random frames on both instances, valid held until accepted.
        for (int c = 0; c < 600; c++) begin
            if (!ifa.res_valid && $urandom_range(0, 3) == 0) begin
                ifa.res_valid = 1'b1;
                ifa.res_in    = 16'($urandom);
                ifa.err_in    = ($urandom_range(0, 7) == 0);
            end
            if (!ifb.res_valid && $urandom_range(0, 3) == 0) begin
                ifb.res_valid = 1'b1;
                ifb.res_in    = 16'($urandom);
                ifb.err_in    = ($urandom_range(0, 7) == 0);
            end
            tick();
            if (acc_a) ifa.res_valid = 1'b0;
            if (acc_b) ifb.res_valid = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_result_display.md
# matrix_result_display

Downstream display stage for the 2x2 matrix multiplier. It captures one frame of four 4-bit results (r11, r12, r21, r22) plus the multiplier's error flag through a valid/ready handshake. It then time-multiplexes the results onto a single seven-segment digit position, one-hot selecting which of four digit enables is lit, and dwells a programmable number of cycles on each. An error frame replaces the numbers with an "E" glyph on all digits.

## Interface
- DWELL_CYCLES, default 1000: cycles each result stays on the display; legal range is 1 or greater (0 is illegal).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- res_valid  in  1  upstream presents a result frame.
- res_in  in  16  frame data {r22, r21, r12, r11}, 4 bits each; r11 = res_in[3:0].
- err_in  in  1  frame is an error frame; qualified by res_valid.
- res_ready  out  1  block accepts a frame this cycle.
- seg  out  7  {g,f,e,d,c,b,a}, active-high.
- digit_sel  out  4  one-hot digit enable; bit i shows result i (0 = r11, 1 = r12, 2 = r21, 3 = r22).
- frame_done  out  1  one-cycle pulse on the last cycle of the r22 dwell.
- error  out  1  high while in the ERR state.

## Operation
- States:
  - IDLE: display blank.
  - SHOW: cycling through the four results.
  - ERR: error glyph.
- Capture occurs on a rising edge where res_valid && res_ready.
  - err_in = 0: latch res_in, go to SHOW with digit index 0 and dwell counter 0.
  - err_in = 1: go to ERR; the data latch keeps its old contents.
- res_ready:
  - 1 in IDLE and ERR.
  - In SHOW, 1 only on the final cycle of digit 3 (the frame boundary, same cycle as frame_done). Displayed frames are therefore never truncated.
  - res_valid outside ready is ignored, with no effect on state or data. Upstream must hold res_valid until it is accepted.
- SHOW sequencing:
  - dwell counter counts 0..DWELL_CYCLES-1.
  - On its terminal count the counter returns to 0 and the digit index increments modulo 4.
  - After digit 3 with no capture, SHOW wraps to digit 0 and keeps showing the latched frame indefinitely.
  - A capture on the boundary cycle restarts at digit 0 with the new data (error frame: go to ERR).
- Glyphs, hex 0-F, {g..a}: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. Values above 8 never arrive from the multiplier but are decoded anyway.
- Outputs per state:
  - IDLE: seg = 0, digit_sel = 0000.
  - SHOW: seg = glyph(result[index]), digit_sel = 1 << index.
  - ERR: seg = 0x79 ("E"), digit_sel = 1111, error = 1, frame_done = 0.
- ERR exits only by a new capture, or by reset.
- All outputs are Moore outputs decoded from registered state, latched data, index and counter. There is no combinational input-to-output path except none: res_ready also depends only on state.

## Timing
- Reset values, applied immediately on assertion, independent of clk:
  - state = IDLE, latch = 0, index = 0, counter = 0.
  - seg = 0, digit_sel = 0, res_ready = 1, frame_done = 0, error = 0.
- Reset mid-frame aborts the frame. No capture happens on any edge while reset is high. First capture is possible on the first edge after deassertion.
- Latency: for a capture at edge k, the r11 glyph is visible in the cycle following edge k.
- Cycle counts, with cycles numbered from the first display cycle:
  - Digit i is displayed for cycles i·D+1 .. (i+1)·D, where D = DWELL_CYCLES.
  - frame_done and res_ready are high on cycle 4D.
  - Cycle 4D+1 shows the next frame's r11.
- DWELL_CYCLES = 1 boundary: digit changes every cycle; frame_done and res_ready are high every 4th cycle.
- Counter width: clog2(DWELL_CYCLES), minimum 1 bit; no overflow is permitted.

## Test plan
All cases use DWELL_CYCLES = 4 unless stated.
- Reset: assert reset asynchronously between edges -> seg = 0, digit_sel = 0000, res_ready = 1, error = 0, frame_done = 0 with no clock edge.
- Normal frame: capture res_in = 16'h8421, err_in = 0 ->
  - cycles 1-4: digit_sel = 0001, seg = 06
  - cycles 5-8: digit_sel = 0010, seg = 5B
  - cycles 9-12: digit_sel = 0100, seg = 66
  - cycles 13-16: digit_sel = 1000, seg = 7F
  - cycle 16: frame_done = 1, res_ready = 1
  - cycle 17: digit_sel = 0001, seg = 06 (wrap)
- Handshake: hold res_valid with 16'h0000 from cycle 6 ->
  - res_ready = 0 until cycle 16; the display is unchanged through cycle 16.
  - Accepted at cycle 16; cycle 17 shows seg = 3F, digit_sel = 0001.
- Error frame: capture with err_in = 1 during the boundary ->
  - Next cycle: error = 1, seg = 79, digit_sel = 1111, res_ready = 1, held indefinitely.
  - Then capture 16'h0002, err_in = 0 -> seg = 5B, digit_sel = 0001, error = 0.
- Reset mid-operation: assert reset during cycle 7 of a frame -> immediate IDLE outputs. After release, showing 16'h8421 again restarts at digit 0.
- DWELL_CYCLES = 1: capture 16'h8421 -> seg sequence 06, 5B, 66, 7F, 06…; frame_done on every 4th cycle.
